// File: rtl/ldo_enable_sequencer.sv
// ldo_enable_sequencer
// Always-on controller for the 3.3 V -> 1.8 V LDO. Synchronizes the VDDA and
// output comparators, sequences EN after VDDA is valid, waits a settle window,
// reports power-good, retries failed ramps/dropouts and latches a fault after
// RETRY_MAX consecutive failures.
//
// Handshake note: this block has no valid/ready channels. req_on is a level
// request held by the register block; clear_fault is a single-cycle pulse that
// is only honoured in FAULT while req_on is low.
//
// All outputs are flops decoded from the next-state value, so they move on the
// same edge as the state register.
module ldo_enable_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 64,  // 1..255
  parameter int unsigned OFF_CYCLES    = 16,  // 1..255
  parameter int unsigned RETRY_MAX     = 3    // 1..7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_on,
  input  logic       clear_fault,
  input  logic       vdda_ok,
  input  logic       out_ok,
  output logic       en,
  output logic       enb,
  output logic       pgood,
  output logic       fault,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_VDDA = 3'd1,
    ST_RAMP      = 3'd2,
    ST_ON        = 3'd3,
    ST_DISCHARGE = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // Counter reload values; a window of N cycles counts N-1 down to 0.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] OFF_LOAD    = 8'(OFF_CYCLES - 1);
  localparam logic [2:0] RETRY_LIM   = 3'(RETRY_MAX);

  // Comparator synchronizers
  logic vdda_meta_q, vdda_meta_d;
  logic vdda_s_q, vdda_s_d;
  logic out_meta_q, out_meta_d;
  logic out_s_q, out_s_d;

  // FSM and counters
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] rty_q, rty_d;
  logic [2:0] rty_inc;

  // Registered outputs
  logic en_q, en_d;
  logic enb_q, enb_d;
  logic pgood_q, pgood_d;
  logic fault_q, fault_d;
  logic busy_q, busy_d;

  // Two-stage synchronizer shift for both asynchronous comparators
  always_comb begin
    vdda_meta_d = vdda_ok;
    vdda_s_d    = vdda_meta_q;
    out_meta_d  = out_ok;
    out_s_d     = out_meta_q;
  end

  // Synchronizer flops, cleared by reset so the FSM starts from "not ok"
  always_ff @(posedge clk) begin
    if (reset) begin
      vdda_meta_q <= 1'b0;
      vdda_s_q    <= 1'b0;
      out_meta_q  <= 1'b0;
      out_s_q     <= 1'b0;
    end else begin
      vdda_meta_q <= vdda_meta_d;
      vdda_s_q    <= vdda_s_d;
      out_meta_q  <= out_meta_d;
      out_s_q     <= out_s_d;
    end
  end

  // Next-state, counter and retry logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rty_d   = rty_q;
    rty_inc = rty_q + 3'd1;

    case (state_q)
      ST_OFF: begin
        if (req_on) begin
          state_d = ST_WAIT_VDDA;
        end
      end

      ST_WAIT_VDDA: begin
        if (!req_on) begin
          state_d = ST_OFF;
        end else if (vdda_s_q) begin
          state_d = ST_RAMP;
          cnt_d   = SETTLE_LOAD;
        end
      end

      ST_RAMP: begin
        // A dropped request or lost supply aborts the ramp without a retry;
        // this takes priority over the end of the settle window.
        if (!req_on || !vdda_s_q) begin
          state_d = ST_DISCHARGE;
          cnt_d   = OFF_LOAD;
        end else if (cnt_q == 8'd0) begin
          if (out_s_q) begin
            state_d = ST_ON;
            rty_d   = 3'd0;
          end else begin
            rty_d = rty_inc;
            if (rty_inc == RETRY_LIM) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_DISCHARGE;
              cnt_d   = OFF_LOAD;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_ON: begin
        // A requested turn-off wins over a simultaneous dropout.
        if (!req_on) begin
          state_d = ST_DISCHARGE;
          cnt_d   = OFF_LOAD;
        end else if (!vdda_s_q || !out_s_q) begin
          rty_d = rty_inc;
          if (rty_inc == RETRY_LIM) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_DISCHARGE;
            cnt_d   = OFF_LOAD;
          end
        end
      end

      ST_DISCHARGE: begin
        // The full discharge window always runs; req_on only picks the exit.
        if (cnt_q == 8'd0) begin
          state_d = req_on ? ST_WAIT_VDDA : ST_OFF;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_FAULT: begin
        if (clear_fault && !req_on) begin
          state_d = ST_OFF;
          rty_d   = 3'd0;
        end
      end

      default: begin
        // Unused encodings recover to OFF with the LDO disabled.
        state_d = ST_OFF;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode from the next state so outputs align with the state register
  always_comb begin
    en_d    = (state_d == ST_RAMP) || (state_d == ST_ON);
    enb_d   = !en_d;
    pgood_d = (state_d == ST_ON);
    fault_d = (state_d == ST_FAULT);
    busy_d  = (state_d == ST_WAIT_VDDA) || (state_d == ST_RAMP) ||
              (state_d == ST_DISCHARGE);
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= 8'd0;
      rty_q   <= 3'd0;
      en_q    <= 1'b0;
      enb_q   <= 1'b1;
      pgood_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rty_q   <= rty_d;
      en_q    <= en_d;
      enb_q   <= enb_d;
      pgood_q <= pgood_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
    end
  end

  assign en    = en_q;
  assign enb   = enb_q;
  assign pgood = pgood_q;
  assign fault = fault_q;
  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: tb/tb_ldo_enable_sequencer.sv
// tb_ldo_enable_sequencer
// Directed walk through power-up, VDDA gating, dropout, abort, ramp failure
// and reset cases, followed by a randomized section. Every cycle the DUT
// outputs are compared against a behavioural model that tracks phase, time
// spent in the phase and the number of consecutive failures.
module tb_ldo_enable_sequencer;

  localparam int SETTLE = 64;
  localparam int OFFC   = 16;
  localparam int RMAX   = 3;

  // Phase codes as published for the state output
  localparam int P_OFF  = 0;
  localparam int P_WAIT = 1;
  localparam int P_RAMP = 2;
  localparam int P_ON   = 3;
  localparam int P_DIS  = 4;
  localparam int P_FLT  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic req_on = 1'b0;
  logic clear_fault = 1'b0;
  logic vdda_ok = 1'b0;
  logic out_ok = 1'b0;
  logic en, enb, pgood, fault, busy;
  logic [2:0] state;

  ldo_enable_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .OFF_CYCLES(OFFC),
    .RETRY_MAX(RMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_on(req_on),
    .clear_fault(clear_fault),
    .vdda_ok(vdda_ok),
    .out_ok(out_ok),
    .en(en),
    .enb(enb),
    .pgood(pgood),
    .fault(fault),
    .busy(busy),
    .state(state)
  );

  // ---------------- counters ----------------
  int n_total = 0;
  int n_bad = 0;
  int en_rises = 0;
  logic prev_en = 1'b0;

  // ---------------- reference model ----------------
  int m_phase = P_OFF;
  int m_time = 0;     // cycles already spent in RAMP / DISCHARGE
  int m_fails = 0;    // consecutive failed ramps or dropouts
  logic vhist[$] = '{1'b0, 1'b0};  // comparator samples still in flight
  logic ohist[$] = '{1'b0, 1'b0};

  logic [7:0] exp_q[$];

  task automatic m_fail();
    m_fails++;
    if (m_fails == RMAX) begin
      m_phase = P_FLT;
    end else begin
      m_phase = P_DIS;
      m_time = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_step();
    logic vs, os;
    logic [7:0] v;
    logic e_en;
    vs = vhist[0];
    os = ohist[0];
    if (reset) begin
      m_phase = P_OFF;
      m_time = 0;
      m_fails = 0;
      vhist = '{1'b0, 1'b0};
      ohist = '{1'b0, 1'b0};
    end else begin
      void'(vhist.pop_front());
      vhist.push_back(vdda_ok);
      void'(ohist.pop_front());
      ohist.push_back(out_ok);
      case (m_phase)
        P_OFF: if (req_on) m_phase = P_WAIT;
        P_WAIT: begin
          if (!req_on) m_phase = P_OFF;
          else if (vs) begin m_phase = P_RAMP; m_time = 0; end
        end
        P_RAMP: begin
          if (!req_on || !vs) begin
            m_phase = P_DIS;
            m_time = 0;
          end else if (m_time == SETTLE - 1) begin
            if (os) begin m_phase = P_ON; m_fails = 0; end
            else m_fail();
          end else begin
            m_time++;
          end
        end
        P_ON: begin
          if (!req_on) begin m_phase = P_DIS; m_time = 0; end
          else if (!vs || !os) m_fail();
        end
        P_DIS: begin
          if (m_time == OFFC - 1) m_phase = req_on ? P_WAIT : P_OFF;
          else m_time++;
        end
        default: begin
          if (clear_fault && !req_on) begin m_phase = P_OFF; m_fails = 0; end
        end
      endcase
    end
    e_en = (m_phase == P_RAMP) || (m_phase == P_ON);
    v[7:5] = 3'(m_phase);
    v[4] = (m_phase == P_WAIT) || (m_phase == P_RAMP) || (m_phase == P_DIS);
    v[3] = (m_phase == P_FLT);
    v[2] = (m_phase == P_ON);
    v[1] = !e_en;
    v[0] = e_en;
    exp_q.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model predicts, DUT advances, outputs compared 1 ns after edge
  task automatic tick();
    logic [7:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("state", int'(state), int'(e[7:5]));
    chk("busy", int'(busy), int'(e[4]));
    chk("fault", int'(fault), int'(e[3]));
    chk("pgood", int'(pgood), int'(e[2]));
    chk("enb", int'(enb), int'(e[1]));
    chk("en", int'(en), int'(e[0]));
    if (en === 1'b1 && prev_en === 1'b0) en_rises++;
    prev_en = en;
  endtask

  function automatic logic obs(input int which);
    case (which)
      0: return en;
      1: return pgood;
      2: return fault;
      3: return state == 3'd0;
      default: return !en;
    endcase
  endfunction

  // Tick until the selected condition holds, bounded by budget
  task automatic wait_for(input int which, input int budget, input string tag,
                          output int took);
    took = 0;
    while (obs(which) !== 1'b1 && took < budget) begin
      tick();
      took++;
    end
    chk(tag, int'(obs(which)), 1);
  endtask

  // Count cycles busy stays high after the current edge
  task automatic busy_len(input string tag);
    int bc;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      tick();
    end
    chk(tag, bc, OFFC);
    chk({tag, "_off"}, int'(state), P_OFF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int r0;

    // Reset
    repeat (3) tick();
    chk("rst_state", int'(state), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_enb", int'(enb), 1);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Nominal power-up
    vdda_ok = 1'b1;
    out_ok = 1'b1;
    repeat (3) tick();
    req_on = 1'b1;
    wait_for(0, 10, "nom_en", t);
    chk("nom_en_lat", t, 2);
    wait_for(1, 200, "nom_pg", t);
    chk("nom_pg_lat", t, SETTLE);

    // Turn-off from ON
    req_on = 1'b0;
    tick();
    chk("off_en", int'(en), 0);
    chk("off_pg", int'(pgood), 0);
    busy_len("off_busy");

    // VDDA gating
    vdda_ok = 1'b0;
    repeat (4) tick();
    req_on = 1'b1;
    repeat (100) tick();
    chk("gate_state", int'(state), P_WAIT);
    chk("gate_en", int'(en), 0);
    vdda_ok = 1'b1;
    wait_for(0, 10, "gate_rise", t);
    chk("gate_lat", t, 3);
    wait_for(1, 200, "gate_pg", t);

    // Dropouts in ON, each recovering; retries must clear on reaching ON
    for (int i = 0; i < 3; i++) begin
      out_ok = 1'b0;
      tick();
      out_ok = 1'b1;
      wait_for(4, 10, "drop_en_low", t);
      chk("drop_delay", t, 2);
      wait_for(1, 300, "drop_repg", t);
    end
    chk("drop_nofault", int'(fault), 0);
    chk("drop_on", int'(state), P_ON);

    // Turn-off during RAMP with 10 settle cycles remaining
    req_on = 1'b0;
    wait_for(3, 50, "abort_pre_off", t);
    req_on = 1'b1;
    wait_for(0, 10, "abort_en", t);
    repeat (SETTLE - 1 - 10) tick();
    chk("abort_ramp", int'(state), P_RAMP);
    req_on = 1'b0;
    tick();
    chk("abort_en_low", int'(en), 0);
    busy_len("abort_busy");

    // Ramp failure: exactly RMAX ramps, then latched fault
    out_ok = 1'b0;
    req_on = 1'b1;
    r0 = en_rises;
    wait_for(2, 800, "rf_fault", t);
    chk("rf_ramps", en_rises - r0, RMAX);
    chk("rf_state", int'(state), P_FLT);
    chk("rf_en", int'(en), 0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    tick();
    chk("rf_clr_ignored", int'(state), P_FLT);
    req_on = 1'b0;
    tick();
    chk("rf_hold", int'(fault), 1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("rf_clr_state", int'(state), P_OFF);
    chk("rf_clr_fault", int'(fault), 0);

    // Reset mid-RAMP
    out_ok = 1'b1;
    req_on = 1'b1;
    wait_for(0, 10, "rr_en", t);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("rr_state", int'(state), 0);
    chk("rr_en", int'(en), 0);
    chk("rr_enb", int'(enb), 1);
    chk("rr_pg", int'(pgood), 0);
    reset = 1'b0;

    // Reset in FAULT
    out_ok = 1'b0;
    wait_for(2, 800, "rf2_fault", t);
    reset = 1'b1;
    tick();
    chk("rflt_fault", int'(fault), 0);
    chk("rflt_state", int'(state), 0);
    chk("rflt_enb", int'(enb), 1);
    reset = 1'b0;
    req_on = 1'b0;
    out_ok = 1'b1;
    repeat (3) tick();

    // Randomized section, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) req_on = !req_on;
      vdda_ok = ($urandom_range(0, 99) < 97);
      out_ok = ($urandom_range(0, 99) < 96);
      clear_fault = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
